// File: rtl/perf_counter_bank_pkg.sv
// perf_cnt_types: shared types and constants for the performance counter bank.
// Holds the per-channel counting mode, the default bank geometry, a helper
// for deriving select widths and the channel map for standard pipeline events.
package perf_cnt_types;

    // Per-channel counting mode; the encoding matches a level_mode bit.
    typedef enum logic {
        CNT_EDGE  = 1'b0,
        CNT_LEVEL = 1'b1
    } cnt_mode_e;

    // Default bank geometry.
    localparam int PERF_N_CH_DEFAULT  = 8;
    localparam int PERF_WIDTH_DEFAULT = 16;

    // Standard channel assignment for pipeline events.
    localparam int EV_STALL         = 0;
    localparam int EV_ICACHE_MISS   = 1;
    localparam int EV_DCACHE_MISS   = 2;
    localparam int EV_BR_MISPREDICT = 3;
    localparam int EV_FLUSH         = 4;
    localparam int EV_LSU_REPLAY    = 5;
    localparam int EV_ITLB_MISS     = 6;
    localparam int EV_DTLB_MISS     = 7;

    // Channel-select width; a single-channel bank still gets a 1-bit select.
    function automatic int sel_width(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/perf_counter_chan.sv
// perf_counter_chan: one event counter channel.
// Tracks edge history, detects hits (edge or level mode), applies the update
// priority clr > preload > hit and keeps a sticky overflow flag.
// Build option: PERF_CNT_SATURATE_EN makes an increment at the maximum hold
// the counter at the maximum instead of wrapping to zero.
module perf_counter_chan
    import perf_cnt_types::*;
#(
    parameter int WIDTH = PERF_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             event_line,
    input  cnt_mode_e        mode,
    input  logic             en,
    input  logic             clr,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] count,
    output logic             ovf,
    output logic             ovf_nxt
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic             prev;
    logic             hit;
    logic [WIDTH-1:0] count_nxt;

    // Increment policy at the top of the range: wrap or saturate.
    function automatic logic [WIDTH-1:0] inc_count(input logic [WIDTH-1:0] cur);
`ifdef PERF_CNT_SATURATE_EN
        return (cur == CNT_MAX) ? CNT_MAX : cur + WIDTH'(1);
`else
        return cur + WIDTH'(1);
`endif
    endfunction

    // Edge mode needs a low-to-high transition; level mode counts every high cycle.
    assign hit = en & event_line & ((mode == CNT_LEVEL) | ~prev);

    // Edge history follows the line every cycle, reset included, so a line
    // already high when reset drops is not mistaken for a fresh edge.
    always_ff @(posedge clk) begin
        prev <= event_line;
    end

    // Next-state with priority clr > preload > hit; a hit colliding with
    // clr or preload is dropped.
    always_comb begin
        count_nxt = count;
        ovf_nxt   = ovf;
        if (clr) begin
            count_nxt = '0;
            ovf_nxt   = 1'b0;
        end else if (wr) begin
            count_nxt = wr_data;
        end else if (hit) begin
            count_nxt = inc_count(count);
            if (count == CNT_MAX) begin
                ovf_nxt = 1'b1;
            end
        end
    end

    // Counter and sticky flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            count <= count_nxt;
            ovf   <= ovf_nxt;
        end
    end

endmodule

// File: rtl/perf_counter_bank.sv
// perf_counter_bank: N_CH independent event counters with global freeze,
// per-channel clear/preload, sticky overflow flags, an all-channel snapshot
// into shadow registers and a registered read port.
// Build option: PERF_CNT_SATURATE_EN (counters saturate instead of wrapping;
// selected inside perf_counter_chan).
module perf_counter_bank
    import perf_cnt_types::*;
#(
    parameter  int N_CH  = PERF_N_CH_DEFAULT,
    parameter  int WIDTH = PERF_WIDTH_DEFAULT,
    localparam int SEL_W = sel_width(N_CH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_CH-1:0]  event_in,
    input  logic [N_CH-1:0]  level_mode,
    input  logic             count_en,
    input  logic [N_CH-1:0]  clr,
    input  logic             wr_en,
    input  logic [SEL_W-1:0] wr_sel,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             snap,
    input  logic [SEL_W-1:0] rd_sel,
    input  logic             rd_shadow,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_ovf,
    output logic             ovf_any
);

    // N_CH always fits in SEL_W+1 bits, which keeps the range check exact.
    localparam logic [SEL_W:0] N_CH_L = (SEL_W + 1)'(N_CH);

    logic [WIDTH-1:0] live_cnt   [N_CH];
    logic [N_CH-1:0]  live_ovf;
    logic [N_CH-1:0]  ovf_nxt;
    logic [WIDTH-1:0] shadow_cnt [N_CH];
    logic [N_CH-1:0]  shadow_ovf;
    logic             rd_in_range;
    logic [WIDTH-1:0] rd_data_p1;
    logic             rd_ovf_p1;
    logic             ovf_any_p1;

    // One counter channel per event line; an out-of-range wr_sel matches none.
    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        logic wr_hit;
        assign wr_hit = wr_en & (wr_sel == SEL_W'(i));

        perf_counter_chan #(
            .WIDTH(WIDTH)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .event_line(event_in[i]),
            .mode      (cnt_mode_e'(level_mode[i])),
            .en        (count_en),
            .clr       (clr[i]),
            .wr        (wr_hit),
            .wr_data   (wr_data),
            .count     (live_cnt[i]),
            .ovf       (live_ovf[i]),
            .ovf_nxt   (ovf_nxt[i])
        );
    end

    // Snapshot captures the pre-update live state of the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                shadow_cnt[i] <= '0;
            end
            shadow_ovf <= '0;
        end else if (snap) begin
            for (int i = 0; i < N_CH; i++) begin
                shadow_cnt[i] <= live_cnt[i];
            end
            shadow_ovf <= live_ovf;
        end
    end

    assign rd_in_range = ({1'b0, rd_sel} < N_CH_L);

    // ---- read stage p1: registered read of pre-update state ----
    // Registered read mux; unmapped selects read as zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_p1 <= '0;
            rd_ovf_p1  <= 1'b0;
        end else if (!rd_in_range) begin
            rd_data_p1 <= '0;
            rd_ovf_p1  <= 1'b0;
        end else if (rd_shadow) begin
            rd_data_p1 <= shadow_cnt[rd_sel];
            rd_ovf_p1  <= shadow_ovf[rd_sel];
        end else begin
            rd_data_p1 <= live_cnt[rd_sel];
            rd_ovf_p1  <= live_ovf[rd_sel];
        end
    end

    // Summary flag built from the post-update flags so it tracks them cycle-exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_any_p1 <= 1'b0;
        end else begin
            ovf_any_p1 <= |ovf_nxt;
        end
    end

    assign rd_data = rd_data_p1;
    assign rd_ovf  = rd_ovf_p1;
    assign ovf_any = ovf_any_p1;

endmodule
